// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable big-endian data memory with request/response handshake.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_wr/req_size/req_unsigned,
// data_addr, data_wdata (request); rsp_valid/rsp_err/rsp_rdata (1-cycle latency response);
// err_flag/err_clr (sticky fault). Optional macro DMEM_PERF_CNT_EN adds rd_count/wr_count.
module data_memory_ctrl #(
    parameter int DEPTH_BYTES    = 1024,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              err_flag,
    input  logic              err_clr
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int IW = AW - 2;
    typedef enum logic {INIT, IDLE} state_t;
    state_t        state;
    logic [IW-1:0] init_idx;
    logic [7:0]    mem [DEPTH_BYTES];
    logic [AW-1:0] a0, a1, a2, a3;
    logic          accept, fault, wr_en;
    logic [31:0]   word, load_val;
    assign accept = req_valid & req_ready;
    assign a0 = data_addr[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign fault = (req_size == 2'b11) | (req_size == 2'b01 & data_addr[0]) |
                   (req_size == 2'b10 & |data_addr[1:0]) | (data_addr >= ADDR_W'(DEPTH_BYTES));
    assign wr_en = accept & req_wr & ~fault;
    // Big-endian: the addressed byte is the most significant, so narrower results come from the top of word
    assign word = {mem[a0], mem[a1], mem[a2], mem[a3]};
    assign load_val = req_size == 2'b10 ? word :
                      req_size == 2'b01 ? {{16{~req_unsigned & word[31]}}, word[31:16]} :
                                          {{24{~req_unsigned & word[31]}}, word[31:24]};
    // Memory array has no reset so it can map onto RAM; the INIT state clears it instead
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[{init_idx, 2'd0}] <= '0;
            mem[{init_idx, 2'd1}] <= '0;
            mem[{init_idx, 2'd2}] <= '0;
            mem[{init_idx, 2'd3}] <= '0;
        end else if (wr_en) begin
            if (req_size == 2'b10) begin
                mem[a0] <= data_wdata[31:24];
                mem[a1] <= data_wdata[23:16];
                mem[a2] <= data_wdata[15:8];
                mem[a3] <= data_wdata[7:0];
            end else if (req_size == 2'b01) begin
                mem[a0] <= data_wdata[15:8];
                mem[a1] <= data_wdata[7:0];
            end else begin
                mem[a0] <= data_wdata[7:0];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? INIT : IDLE;
            init_idx  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            err_flag  <= 1'b0;
`ifdef DMEM_PERF_CNT_EN
            rd_count  <= '0;
            wr_count  <= '0;
`endif
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & fault;
            rsp_rdata <= (accept & ~fault & ~req_wr) ? load_val : '0;
            // A new fault beats a simultaneous clear
            err_flag  <= (accept & fault) | (err_flag & ~err_clr);
            if (state == INIT) begin
                init_idx <= init_idx + IW'(1);
                if (&init_idx) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            end else begin
                req_ready <= 1'b1;
            end
`ifdef DMEM_PERF_CNT_EN
            if (accept & ~fault & ~req_wr) rd_count <= rd_count + 32'd1;
            if (wr_en) wr_count <= wr_count + 32'd1;
`endif
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and random checks of data_memory_ctrl against a byte-array reference model.
module tb_data_memory_ctrl;
    localparam int DEPTH = 64;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_wr = 0, req_unsigned = 0, err_clr = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] data_addr = 0, data_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err, err_flag;
    logic [31:0] rsp_rdata;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_count, wr_count;
`endif
    int          total = 0, bad = 0;
    logic [7:0]  ref_mem [DEPTH];
    bit          err_model = 0;
    int unsigned rd_exp = 0, wr_exp = 0;

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .data_addr(data_addr),
        .data_wdata(data_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .err_flag(err_flag), .err_clr(err_clr)
`ifdef DMEM_PERF_CNT_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        err_model = 0;
        rd_exp = 0;
        wr_exp = 0;
    endtask

    task automatic model(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                         input logic [31:0] wd, input bit clr, output bit ef, output logic [31:0] ev);
        int nb;
        longint v;
        nb = 1 << sz;
        ef = (sz == 2'b11) || (a % nb != 0) || (a >= DEPTH);
        ev = 0;
        if (!ef && wr) begin
            for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(wd >> (8 * (nb - 1 - i)));
            wr_exp++;
        end else if (!ef) begin
            v = 0;
            for (int i = 0; i < nb; i++) v = (v << 8) | longint'(ref_mem[a + i]);
            if (!uns && nb < 4 && v[8 * nb - 1]) v -= (longint'(1) << (8 * nb));
            ev = v[31:0];
            rd_exp++;
        end
        err_model = ef ? 1'b1 : clr ? 1'b0 : err_model;
    endtask

    task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                          input logic [31:0] wd, input bit clr, input string tag);
        bit          ef;
        logic [31:0] ev;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        model(wr, sz, uns, a, wd, clr, ef, ev);
        req_valid = 1; req_wr = wr; req_size = sz; req_unsigned = uns;
        data_addr = a; data_wdata = wd; err_clr = clr;
        @(posedge clk); #1;
        req_valid = 0; err_clr = 0;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".err"}, 32'(rsp_err), 32'(ef));
        chk({tag, ".rdata"}, rsp_rdata, ev);
        chk({tag, ".eflag"}, 32'(err_flag), 32'(err_model));
`ifdef DMEM_PERF_CNT_EN
        chk({tag, ".rdcnt"}, rd_count, rd_exp);
        chk({tag, ".wrcnt"}, wr_count, wr_exp);
`endif
    endtask

    task automatic idle(input bit clr);
        err_clr = clr;
        @(posedge clk); #1;
        err_clr = 0;
        if (clr) err_model = 0;
        chk("idle.valid", 32'(rsp_valid), 32'd0);
        chk("idle.eflag", 32'(err_flag), 32'(err_model));
    endtask

    // Counts cycles with req_ready low from now on, plus any stray responses
    task automatic init_wait(input string tag);
        int n = 0, nv = 0;
        while (!req_ready && n < 100) begin
            n++;
            if (rsp_valid) nv++;
            @(posedge clk); #1;
        end
        chk({tag, ".len"}, n, 16);
        chk({tag, ".rsp"}, nv, 0);
        model_reset();
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [1:0]  sz;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 32'(req_ready), 0);
        chk("rst.valid", 32'(rsp_valid), 0);
        chk("rst.err", 32'(rsp_err), 0);
        chk("rst.rdata", rsp_rdata, 0);
        chk("rst.eflag", 32'(err_flag), 0);
        rst = 0;
        init_wait("init");
        do_req(0, 2'b10, 0, 32'h3C, 0, 0, "ld3c");
        chk("ld3c.const", rsp_rdata, 32'h0);

        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, "stw10");
        idle(0);
        do_req(0, 2'b00, 1, 32'h10, 0, 0, "lb10");
        chk("lb10.const", rsp_rdata, 32'h000000DE);
        do_req(0, 2'b00, 1, 32'h11, 0, 0, "lb11");
        chk("lb11.const", rsp_rdata, 32'h000000AD);
        do_req(0, 2'b00, 1, 32'h12, 0, 0, "lb12");
        chk("lb12.const", rsp_rdata, 32'h000000BE);
        do_req(0, 2'b00, 1, 32'h13, 0, 0, "lb13");
        chk("lb13.const", rsp_rdata, 32'h000000EF);
        idle(0);

        do_req(1, 2'b01, 0, 32'h20, 32'hFFFF8001, 0, "sth20");
        do_req(0, 2'b01, 0, 32'h20, 0, 0, "lhs20");
        chk("lhs20.const", rsp_rdata, 32'hFFFF8001);
        do_req(0, 2'b01, 1, 32'h20, 0, 0, "lhu20");
        chk("lhu20.const", rsp_rdata, 32'h00008001);
        do_req(0, 2'b00, 0, 32'h21, 0, 0, "lbs21");
        chk("lbs21.const", rsp_rdata, 32'h00000001);

        do_req(1, 2'b10, 0, 32'h12, 32'hCAFEBABE, 0, "stw12");
        chk("stw12.const", 32'(rsp_err), 1);
        do_req(0, 2'b01, 0, 32'h05, 0, 0, "lh05");
        chk("lh05.const", rsp_rdata, 0);
        do_req(0, 2'b10, 0, 32'h10, 0, 0, "lw10");
        chk("lw10.const", rsp_rdata, 32'hDEADBEEF);
        chk("lw10.eflag", 32'(err_flag), 1);
        do_req(0, 2'b11, 0, 32'h00, 0, 1, "rsvclr");
        chk("rsvclr.eflag", 32'(err_flag), 1);
        do_req(1, 2'b00, 0, DEPTH, 32'h55, 0, "sbrange");
        do_req(0, 2'b00, 1, DEPTH - 1, 0, 1, "lbclr");
        chk("lbclr.eflag", 32'(err_flag), 0);
        do_req(1, 2'b10, 0, 32'h00, 32'h11223344, 0, "b2b.st");
        do_req(0, 2'b10, 0, 32'h00, 0, 0, "b2b.ld");
        chk("b2b.const", rsp_rdata, 32'h11223344);
        idle(0);

        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("init5.ready", 32'(req_ready), 0);
        end
        rst = 1;
        @(posedge clk); #1;
        chk("init5.rstvalid", 32'(rsp_valid), 0);
        rst = 0;
        init_wait("reinit");
        do_req(0, 2'b10, 0, 32'h00, 0, 0, "clr0");
        do_req(1, 2'b10, 0, 32'h04, 32'hA1B2C3D4, 0, "pc.st1");
        do_req(1, 2'b00, 0, 32'h09, 32'h7F, 0, "pc.st2");
        do_req(0, 2'b10, 0, 32'h04, 0, 0, "pc.ld1");
        do_req(0, 2'b01, 0, 32'h03, 0, 0, "pc.flt");
        do_req(0, 2'b00, 0, 32'h09, 0, 0, "pc.ld2");
`ifdef DMEM_PERF_CNT_EN
        chk("pc.rd3", rd_count, 3);
        chk("pc.wr2", wr_count, 2);
`endif
        idle(1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle(1'($urandom_range(0, 1)));
            end else begin
                sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
                a = $urandom_range(0, DEPTH + 8);
                if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
                if ($urandom_range(0, 19) == 0) a = $urandom;
                wd = $urandom;
                do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd,
                       1'($urandom_range(0, 7) == 0), "rnd");
            end
        end

        req_valid = 1; req_wr = 0; req_size = 2'b10; data_addr = 32'h04;
        @(posedge clk);
        rst = 1;
        #1;
        req_valid = 0;
        chk("pend.valid", 32'(rsp_valid), 0);
        chk("pend.eflag", 32'(err_flag), 0);
        @(posedge clk); #1;
        rst = 0;
        init_wait("pend.init");
        do_req(0, 2'b10, 0, 32'h04, 0, 0, "pend.ld");
        chk("pend.const", rsp_rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressable, big-endian data memory for the CPU datapath load/store stage.
- Successor to the fixed 32-bit word memory; adds byte, halfword and word access, sign or zero extension, and a registered read.
- Adds a request/response handshake, alignment and range checking, and a post-reset memory clear sequence.
- Sits between the execute/memory pipeline stage and on-chip RAM.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; power of two, at least 8.
- ADDR_W, 32, width of data_addr; addresses at or above DEPTH_BYTES are out of range.
- CLEAR_ON_RESET, 1, 1 = run the INIT clear sequence after reset; 0 = go straight to IDLE with memory contents undefined.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- req_unsigned  in  1  load only; 1 = zero-extend, 0 = sign-extend.
- data_addr  in  ADDR_W  byte address.
- data_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  qualifies rsp_valid; the request faulted.
- rsp_rdata  out  32  load result; 0 for stores and faults.
- err_flag  out  1  sticky fault indicator.
- err_clr  in  1  clears err_flag.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, err_flag=0. FSM enters INIT (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0).
- INIT:
  - Writes 0 to one 4-byte word per cycle, ascending from address 0.
  - Lasts DEPTH_BYTES/4 cycles; req_ready=0 throughout.
  - Moves to IDLE after the last word.
  - rst asserted during INIT restarts INIT from word 0.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid && req_ready at a rising edge.
- Response timing:
  - Every accepted request gives exactly one rsp_valid pulse on the following cycle (latency 1).
  - Back-to-back requests are allowed every cycle, giving back-to-back responses.
  - There is no response backpressure.
- Byte order (big-endian): byte at address A maps to the most-significant byte of a word or halfword.
  - Word at A: data_wdata[31:24] goes to A, [23:16] to A+1, [15:8] to A+2, [7:0] to A+3.
  - Halfword at A: data_wdata[15:8] goes to A, [7:0] to A+1.
  - Byte: data_wdata[7:0]. Unused upper wdata bits are ignored.
- Loads:
  - Read is synchronous; the result is registered into rsp_rdata.
  - Byte and halfword results are right-justified and extended according to req_unsigned.
- Fault conditions (any one):
  - req_size=11.
  - Halfword at odd address.
  - Word at address not a multiple of 4.
  - data_addr >= DEPTH_BYTES; address bits above log2(DEPTH_BYTES) must be zero.
- Fault response: rsp_err=1, rsp_rdata=0, no memory write, err_flag set on the same edge that rsp_valid asserts.
- Non-fault response: rsp_err=0.
- err_flag: sticky until err_clr. If err_clr and a new fault occur in the same cycle, the set wins.
- Read-after-write: a load accepted the cycle after a store to the same address returns the new data. No forwarding is needed because the write completes at the accept edge.
- A store response has rsp_rdata=0.
- rst mid-operation: any pending response is dropped (rsp_valid=0). Memory contents are re-cleared only if CLEAR_ON_RESET=1.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- Defined:
  - Adds outputs rd_count[31:0] and wr_count[31:0].
  - Each counts successfully completed (non-faulting) loads and stores respectively, incremented with rsp_valid.
  - Both counters reset to 0 on rst and wrap from 0xFFFFFFFF to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with DEPTH_BYTES=64, CLEAR_ON_RESET=1 -> req_ready=0 for exactly 16 cycles, then 1. A word load at 0x3C then returns 0x00000000 with rsp_err=0.
- Word store 0xDEADBEEF at 0x10, then byte loads 0x10..0x13 unsigned -> 0x000000DE, 0x000000AD, 0x000000BE, 0x000000EF. Each rsp_valid arrives 1 cycle after its accept.
- Halfword store 0x8001 at 0x20; halfword load at 0x20:
  - signed -> 0xFFFF8001.
  - unsigned -> 0x00008001.
  - byte load at 0x21, signed -> 0x00000001.
- Word store at 0x12 and halfword load at 0x05 -> rsp_err=1, rsp_rdata=0, memory at 0x10 unchanged, err_flag=1. Assert err_clr together with a fault on req_size=11 -> err_flag stays 1.
- Byte store at data_addr=DEPTH_BYTES -> rsp_err=1, no write. Back-to-back store 0x11223344 at 0x0 followed by a word load at 0x0 on the next cycle -> load returns 0x11223344.
- Assert rst during INIT (cycle 5) and during a pending load response -> rsp_valid stays 0 and INIT restarts for a full 16 cycles. With DMEM_PERF_CNT_EN defined, after 3 good loads, 2 good stores and 1 fault -> rd_count=3, wr_count=2.
